// File: rtl/muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle; div-by-zero, overflow and reserved ops resolve at capture.
module muldiv_seq (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [3:0]  op_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic        exe_wait_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;     // product accumulator / partial remainder
    logic [63:0] m_q, m_d;         // multiplicand / divisor magnitude
    logic [63:0] q_q, q_d;         // multiplier / dividend-then-quotient
    logic        mul_q, mul_d;
    logic        rem_q, rem_d;
    logic        word_q, word_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;

    // Capture-time decode
    logic [2:0]  code;
    logic        word, is_mul, is_rem, is_sdiv, is_udiv, reserved;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, min_neg, fast_res;
    logic        sa, sb, div_zero, ovf;

    always_comb begin
        code     = op_i[2:0];
        word     = op_i[3];
        is_mul   = (code == OP_MUL);
        is_sdiv  = (code == OP_DIV)  || (code == OP_REM);
        is_udiv  = (code == OP_DIVU) || (code == OP_REMU);
        is_rem   = (code == OP_REM)  || (code == OP_REMU);
        reserved = (code > OP_REMU);
        a_ext    = word ? (is_udiv ? {32'b0, a_i[31:0]} : sext32(a_i[31:0])) : a_i;
        b_ext    = word ? (is_udiv ? {32'b0, b_i[31:0]} : sext32(b_i[31:0])) : b_i;
        sa       = is_sdiv & a_ext[63];
        sb       = is_sdiv & b_ext[63];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        min_neg  = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = (is_sdiv | is_udiv) && (b_ext == 64'd0);
        ovf      = is_sdiv && (a_ext == min_neg) && (b_ext == '1);
        fast_res = 64'd0;
        if (div_zero)
            fast_res = is_rem ? (word ? sext32(a_i[31:0]) : a_i) : '1;
        else if (ovf)
            fast_res = is_rem ? 64'd0 : a_ext;
    end

    // One iteration of the active algorithm
    logic [63:0] mul_sum, step_acc, step_m, step_q, q_fix, r_fix, raw_res, fin_res;
    logic [64:0] shifted, diff;
    logic        ge;

    always_comb begin
        mul_sum = acc_q + (q_q[0] ? m_q : 64'd0);
        shifted = {acc_q, q_q[63]};
        diff    = shifted - {1'b0, m_q};
        ge      = ~diff[64];
        if (mul_q) begin
            step_acc = mul_sum;
            step_m   = m_q << 1;
            step_q   = q_q >> 1;
        end else begin
            step_acc = ge ? diff[63:0] : shifted[63:0];
            step_m   = m_q;
            step_q   = {q_q[62:0], ge};
        end
        q_fix   = qneg_q ? -step_q : step_q;
        r_fix   = rneg_q ? -step_acc : step_acc;
        raw_res = mul_q ? step_acc : (rem_q ? r_fix : q_fix);
        fin_res = word_q ? sext32(raw_res[31:0]) : raw_res;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 7'd0;
            acc_q    <= 64'd0;
            m_q      <= 64'd0;
            q_q      <= 64'd0;
            mul_q    <= 1'b0;
            rem_q    <= 1'b0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            q_q      <= q_d;
            mul_q    <= mul_d;
            rem_q    <= rem_d;
            word_q   <= word_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        mul_d      = mul_q;
        rem_d      = rem_q;
        word_d     = word_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        result_d   = result_q;
        exe_wait_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    exe_wait_o = 1'b1;
                    mul_d      = is_mul;
                    rem_d      = is_rem;
                    word_d     = word;
                    qneg_d     = sa ^ sb;
                    rneg_d     = sa;
                    acc_d      = 64'd0;
                    m_d        = is_mul ? a_ext : b_mag;
                    q_d        = is_mul ? b_ext : (word ? {a_mag[31:0], 32'd0} : a_mag);
                    if (reserved || div_zero || ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = word ? 7'd31 : 7'd63;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                exe_wait_o = 1'b1;
                acc_d      = step_acc;
                m_d        = step_m;
                q_d        = step_q;
                if (cnt_q == 7'd0) begin
                    result_d = fin_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush aborts without publishing anything
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
            done_o   = 1'b0;
        end
    end

    assign result_o = result_q;

endmodule
